ad_sample_fifo: RTL and testbench
=================================

// Module: ad_sample_fifo
// PURPOSE
//  Synchronous sample FIFO that consumes the STORE-state write stream (wr_en = STORE, wr_data = 10-bit AD word).
//  Buffers AD samples captured after a valid frequency lock and hands them to a downstream reader (display/UART) via rd_en/rd_valid.
//  Single clock domain (50 MHz system clock). Flags give full, empty and occupancy; a sticky overflow flag records samples dropped while full.
// PARAMETERS
//  DATA_W   10    width of one AD sample
//  ADDR_W   10    address width; depth = 2**ADDR_W = 1024 samples
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  rst_n      in   1        asynchronous reset, active low
//  clr        in   1        synchronous flush: empties FIFO, clears overflow
//  wr_en      in   1        write strobe, one sample per cycle while high
//  wr_data    in   DATA_W   AD sample to store
//  rd_en      in   1        read request, one sample per cycle while high
//  rd_data    out  DATA_W   read sample, valid when rd_valid=1, held otherwise
//  rd_valid   out  1        one-cycle pulse, rd_data carries the accepted read
//  full       out  1        count == 2**ADDR_W
//  empty      out  1        count == 0
//  count      out  ADDR_W+1 current occupancy 0..2**ADDR_W
//  overflow   out  1        sticky; set on write attempt while full
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0. RAM contents not reset.
//  - Pointers ADDR_W bits, wrap 2**ADDR_W-1 -> 0 naturally. count is separate ADDR_W+1-bit counter.
//  - Write accepted iff wr_en && (!full || rd_acc). Accepted write stores wr_data at wr_ptr, wr_ptr++.
//  - Read accepted (rd_acc) iff rd_en && !empty. rd_ptr++. rd_data/rd_valid registered: 1-cycle latency from accepting edge.
//  - count: +1 write only, -1 read only, unchanged both or neither. full/empty registered, derived from next count.
//  - Full + wr_en + rd_en: both accepted, count stays full, no overflow.
//  - Full + wr_en, no read: write dropped, overflow<=1 (sticky).
//  - Empty + rd_en: read ignored, rd_valid stays 0. Empty + wr_en + rd_en: write only, no read-through (rd_valid 0 that cycle).
//  - rd_en/wr_en on a cleared/empty FIFO are harmless; no X propagation on rd_data.
//  - clr has priority over wr_en/rd_en the same cycle: pointers/count->0, overflow->0, rd_valid->0, rd_data held.
//  - Async reset mid-burst: all state to reset values immediately; next write lands at address 0.
//  - No FSM needed beyond pointer/count registers; control is purely accept-logic above.
// STRUCTURE
//  - Shared include (jnu_defs.vh): AD_DATA_W=10, SAMPLE_FIFO_AW=10 constants so top, fft_ctrl and this block agree.
//  - Sub-module sdp_ram (simple dual-port, 1 write port, 1 registered read port, DATA_W x 2**ADDR_W), inferable as block RAM.
//  - ad_sample_fifo holds pointers, count, flags, overflow and rd_valid pipeline register.
// TESTING
//  1 Reset: hold rst_n=0 mid-cycle -> empty=1, full=0, count=0, overflow=0, rd_valid=0 with no clock edge required.
//  2 Write 5 samples 0x001..0x005, then rd_en 5 cycles -> rd_valid 1 cycle after each request, rd_data 0x001..0x005 in order, empty=1 at end.
//  3 Write 1024 samples (ramp 0..1023 mod 2**10) -> full=1, count=1024; 1025th write -> dropped, overflow=1; read all -> ramp intact.
//  4 Full + wr_en + rd_en same cycle (wr 0x3FF) -> count stays 1024, overflow stays 0, 0x3FF read last after draining.
//  5 Wrap: write/read 1500 samples interleaved (count<=8) -> data order preserved across pointer wrap at 1023->0.
//  6 clr asserted with wr_en=1, rd_en=1, count=10, overflow=1 -> next cycle count=0, empty=1, overflow=0, rd_valid=0.

Source files
------------

// File: rtl/ad_sample_fifo_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : ad_sample_fifo_pkg                                         |
// | Brief   : Shared AD sample width and sample FIFO depth constants     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package ad_sample_fifo_pkg;
  localparam int AD_DATA_W      = 10;
  localparam int SAMPLE_FIFO_AW = 10;
endpackage

`default_nettype wire

// File: rtl/sdp_ram.sv
// +----------------------------------------------------------------------+
// | Module  : sdp_ram                                                    |
// | Brief   : Simple dual-port RAM, one write port, one registered read  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module sdp_ram
  import ad_sample_fifo_pkg::*;
#(
  parameter int DATA_W = AD_DATA_W,
  parameter int ADDR_W = SAMPLE_FIFO_AW
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_q;

  // Read-before-write on a shared address: the full+read+write case relies on this.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

`default_nettype wire

// File: rtl/ad_sample_fifo.sv
// +----------------------------------------------------------------------+
// | Module  : ad_sample_fifo                                             |
// | Brief   : Single-clock AD sample FIFO with count and sticky overflow |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module ad_sample_fifo
  import ad_sample_fifo_pkg::*;
#(
  parameter int DATA_W = AD_DATA_W,
  parameter int ADDR_W = SAMPLE_FIFO_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic              r_full, r_empty, r_overflow, r_rd_valid;
  logic [DATA_W-1:0] w_ram_q, r_rd_hold;
  logic              w_rd_acc, w_wr_acc, w_wr_drop;

  always_comb begin
    w_rd_acc    = rd_en && !r_empty && !clr;
    w_wr_acc    = wr_en && (!r_full || w_rd_acc) && !clr;
    w_wr_drop   = wr_en && r_full && !w_rd_acc && !clr;
    w_count_nxt = r_count;
    if (clr)
      w_count_nxt = '0;
    else if (w_wr_acc && !w_rd_acc)
      w_count_nxt = r_count + (ADDR_W+1)'(1);
    else if (w_rd_acc && !w_wr_acc)
      w_count_nxt = r_count - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_hold  <= '0;
    end else begin
      if (clr) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == c_DEPTH);
      r_empty    <= (w_count_nxt == '0);
      if (clr)
        r_overflow <= 1'b0;
      else if (w_wr_drop)
        r_overflow <= 1'b1;
      r_rd_valid <= w_rd_acc;
      // RAM output register is not reset, so the last good sample is kept here.
      if (r_rd_valid) r_rd_hold <= w_ram_q;
    end
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  assign rd_data  = r_rd_valid ? w_ram_q : r_rd_hold;
  assign rd_valid = r_rd_valid;
  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ad_sample_fifo.sv
// +----------------------------------------------------------------------+
// | Module  : tb_ad_sample_fifo                                          |
// | Brief   : Scoreboard bench for ad_sample_fifo                        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ad_sample_fifo;

  logic       clk, rst_n, clr, wr_en, rd_en;
  logic [9:0] wr_data;
  logic [9:0] rd_data;
  logic       rd_valid, full, empty, overflow;
  logic [10:0] count;

  int checks = 0;
  int errors = 0;

  logic [9:0] model [$];
  logic [9:0] exp_q [$];
  logic [9:0] mon_exp;
  logic [9:0] last_rd = '0;
  bit         m_ovf = 0;

  ad_sample_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard consumer: every rd_valid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_rd_valid rd_data=%h required no read", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          errors++;
          $display("FAIL rd_data got=%h exp=%h", rd_data, mon_exp);
        end
        last_rd = rd_data;
      end
    end
  end

  task automatic step(input bit w, input logic [9:0] d, input bit r);
    bit ra, wa;
    ra = r && (model.size() > 0);
    wa = w && ((model.size() < 1024) || ra);
    if (w && !wa) m_ovf = 1;
    if (ra) exp_q.push_back(model.pop_front());
    if (wa) model.push_back(d);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic do_clr();
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    model.delete();
    m_ovf = 0;
  endtask

  task automatic test_reset();
    step(1, 10'h011, 0);
    step(1, 10'h022, 0);
    step(1, 10'h033, 0);
    #2 rst_n = 0;
    #1;
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL rst_full got=%b exp=0", full); end
    checks++; if (count !== 11'd0)   begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 10'h0) begin errors++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
    model.delete(); exp_q.delete(); m_ovf = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    step(1, 10'h2A5, 0);
    step(0, 10'h0, 1);
    step(0, 10'h0, 0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_first_read pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_basic();
    step(1, 10'h001, 1);  // empty: write only, no read-through
    for (int i = 2; i <= 5; i++) step(1, 10'(i), 0);
    for (int i = 0; i < 5; i++) step(0, 10'h0, 1);
    step(0, 10'h0, 0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_reads pending=%0d exp=0", exp_q.size()); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL basic_empty got=%b exp=1", empty); end
    checks++; if (count !== 11'd0)   begin errors++; $display("FAIL basic_count got=%0d exp=0", count); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 1024; i++) step(1, 10'(i), 0);
    checks++; if (full !== 1'b1)        begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 11'd1024)   begin errors++; $display("FAIL fill_count got=%0d exp=1024", count); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL fill_overflow got=%b exp=0", overflow); end
    step(1, 10'h155, 0);
    checks++; if (overflow !== m_ovf)   begin errors++; $display("FAIL ovf_set got=%b exp=%b", overflow, m_ovf); end
    checks++; if (count !== 11'd1024)   begin errors++; $display("FAIL ovf_count got=%0d exp=1024", count); end
    for (int i = 0; i < 1024; i++) step(0, 10'h0, 1);
    step(0, 10'h0, 0);
    checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL ramp_reads pending=%0d exp=0", exp_q.size()); end
    checks++; if (empty !== 1'b1)       begin errors++; $display("FAIL ramp_empty got=%b exp=1", empty); end
    checks++; if (overflow !== 1'b1)    begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_full_rw();
    do_clr();
    for (int i = 0; i < 1024; i++) step(1, 10'(i) ^ 10'h2AA, 0);
    step(1, 10'h3FF, 1);
    checks++; if (count !== 11'd1024)   begin errors++; $display("FAIL frw_count got=%0d exp=1024", count); end
    checks++; if (full !== 1'b1)        begin errors++; $display("FAIL frw_full got=%b exp=1", full); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL frw_overflow got=%b exp=0", overflow); end
    for (int i = 0; i < 1024; i++) step(0, 10'h0, 1);
    step(0, 10'h0, 0);
    checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL frw_reads pending=%0d exp=0", exp_q.size()); end
    checks++; if (last_rd !== 10'h3FF)  begin errors++; $display("FAIL frw_last got=%h exp=3ff", last_rd); end
  endtask

  task automatic test_wrap();
    int written = 0;
    int guard = 0;
    while (written < 1500 && guard < 20000) begin
      bit w;
      w = (model.size() < 8) && ($urandom_range(0, 3) != 0);
      step(w, 10'(written * 7 + 3), bit'($urandom_range(0, 1)));
      if (w) written++;
      guard++;
    end
    checks++; if (written != 1500) begin errors++; $display("FAIL wrap_budget written=%0d exp=1500", written); end
    while (model.size() > 0 && guard < 25000) begin
      step(0, 10'h0, 1);
      guard++;
    end
    step(0, 10'h0, 0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_reads pending=%0d exp=0", exp_q.size()); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 1025; i++) step(1, 10'(i * 3), 0);
    for (int i = 0; i < 1014; i++) step(0, 10'h0, 1);
    checks++; if (count !== 11'd10)   begin errors++; $display("FAIL pre_clr_count got=%0d exp=10", count); end
    checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL pre_clr_overflow got=%b exp=1", overflow); end
    clr = 1; wr_en = 1; wr_data = 10'h077; rd_en = 1;
    @(posedge clk); #1;
    clr = 0; wr_en = 0; rd_en = 0;
    model.delete(); m_ovf = 0;
    checks++; if (count !== 11'd0)    begin errors++; $display("FAIL clr_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL clr_empty got=%b exp=1", empty); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL clr_overflow got=%b exp=0", overflow); end
    checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL clr_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== last_rd) begin errors++; $display("FAIL clr_rd_hold got=%h exp=%h", rd_data, last_rd); end
    step(1, 10'h0AB, 0);
    step(0, 10'h0, 1);
    step(0, 10'h0, 0);
    checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL clr_after_read pending=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 0; clr = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    #12 rst_n = 1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_full_overflow();
    test_full_rw();
    test_wrap();
    test_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
